instruction_fetch_unit: RTL and testbench

//  Front end of the KGP_RISC core. Owns the PC, issues word fetches to instruction memory and

---
 rtl/kgp_risc_pkg.sv | 16 +
 rtl/fetch_target_sel.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared types and constants for the KGP_RISC front end.
// Holds the fetch FSM state encoding and instruction/jump field widths.
package kgp_risc_pkg;

   localparam int INSTR_W  = 32;
   localparam int J_ADDR_W = 26;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      WAIT  = 2'b01,
      HOLD  = 2'b10,
      DROP  = 2'b11
   } fetch_state_t;

endpackage

// File: rtl/fetch_target_sel.sv
// Next-PC priority mux: redirect beats jump, jump beats sequential pc+4.
// take_redirect flags that the control flow changes on this edge.
module fetch_target_sel
   import kgp_risc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]   pc,
   input  logic [ADDR_W-29:0]  pc_region,
   input  logic                jump_valid,
   input  logic [J_ADDR_W-1:0] j_addr,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_target,
   output logic [ADDR_W-1:0]   next_pc,
   output logic                take_redirect
);

   localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   // select the next pc; the sequential sum wraps naturally at the top of memory
   always_comb begin
      next_pc       = pc + PC_STEP;
      take_redirect = 1'b0;
      if (redirect_valid) begin
         next_pc       = redirect_target & ALIGN_MASK;
         take_redirect = 1'b1;
      end else if (jump_valid) begin
         next_pc       = {pc_region, j_addr, 2'b00};
         take_redirect = 1'b1;
      end else begin
         next_pc       = pc + PC_STEP;
         take_redirect = 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// KGP_RISC fetch unit: owns the pc, issues single outstanding imem fetches and
// hands instruction words to the decoder, squashing anything a redirect makes stale.
module instruction_fetch_unit
   import kgp_risc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                instr_valid,
   input  logic                dec_ready,
   input  logic                jump_valid,
   input  logic [J_ADDR_W-1:0] j_addr,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_target
);

   fetch_state_t        state_r, state_nxt_s;
   logic [ADDR_W-1:0]   pc_r, pc_nxt_s;
   logic                imem_req_r, imem_req_nxt_s;
   logic [ADDR_W-1:0]   imem_addr_r, imem_addr_nxt_s;
   logic [INSTR_W-1:0]  instr_r, instr_nxt_s;
   logic [ADDR_W-1:0]   instr_pc_r, instr_pc_nxt_s;
   logic                instr_valid_r, instr_valid_nxt_s;
   logic [ADDR_W-1:0]   sel_pc_s;
   logic                take_redirect_s;

   fetch_target_sel #(
      .ADDR_W (ADDR_W)
   ) u_target_sel (
      .pc              (pc_r),
      .pc_region       (instr_pc_r[ADDR_W-1:28]),
      .jump_valid      (jump_valid),
      .j_addr          (j_addr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .next_pc         (sel_pc_s),
      .take_redirect   (take_redirect_s)
   );

   // next-state and next-output logic; pc always names the word being fetched or next to fetch
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      imem_req_nxt_s    = 1'b0;
      imem_addr_nxt_s   = imem_addr_r;
      instr_nxt_s       = instr_r;
      instr_pc_nxt_s    = instr_pc_r;
      instr_valid_nxt_s = instr_valid_r;
      if (take_redirect_s) begin
         pc_nxt_s          = sel_pc_s;
         instr_valid_nxt_s = 1'b0;
         case (state_r)
            WAIT:    state_nxt_s = imem_rvalid ? FETCH : DROP;
            DROP:    state_nxt_s = imem_rvalid ? FETCH : DROP;
            default: state_nxt_s = FETCH;
         endcase
      end else begin
         case (state_r)
            FETCH: begin
               imem_req_nxt_s  = 1'b1;
               imem_addr_nxt_s = pc_r;
               state_nxt_s     = WAIT;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  instr_nxt_s       = imem_rdata;
                  instr_pc_nxt_s    = pc_r;
                  instr_valid_nxt_s = 1'b1;
                  pc_nxt_s          = sel_pc_s;
                  state_nxt_s       = HOLD;
               end else begin
                  state_nxt_s = WAIT;
               end
            end
            HOLD: begin
               if (dec_ready) begin
                  instr_valid_nxt_s = 1'b0;
                  imem_req_nxt_s    = 1'b1;
                  imem_addr_nxt_s   = pc_r;
                  state_nxt_s       = WAIT;
               end else begin
                  state_nxt_s = HOLD;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = DROP;
               end
            end
            default: begin
               state_nxt_s = FETCH;
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= FETCH;
         pc_r          <= RESET_PC;
         imem_req_r    <= 1'b0;
         imem_addr_r   <= RESET_PC;
         instr_r       <= {INSTR_W{1'b0}};
         instr_pc_r    <= {ADDR_W{1'b0}};
         instr_valid_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         imem_req_r    <= imem_req_nxt_s;
         imem_addr_r   <= imem_addr_nxt_s;
         instr_r       <= instr_nxt_s;
         instr_pc_r    <= instr_pc_nxt_s;
         instr_valid_r <= instr_valid_nxt_s;
      end
   end

   assign imem_req    = imem_req_r;
   assign imem_addr   = imem_addr_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory,
// a transaction-level fetch model checked every cycle, and literal expectations.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        dec_ready;
   logic        jump_valid;
   logic [25:0] j_addr;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   int checks = 0;
   int errors = 0;

   // memory responder controls
   int          lat = 1;
   logic        stray_req = 1'b0;
   logic        mem_pend = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr_q = 32'h0;

   // transaction model state
   logic        m_live = 1'b0;
   logic [31:0] m_next_addr, m_addr_hold, m_out_addr, m_pc, m_instr, m_last_pc;
   logic        m_outstanding, m_stale, m_show;

   instruction_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .dec_ready       (dec_ready),
      .jump_valid      (jump_valid),
      .j_addr          (j_addr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_000C) return 32'h1234_5678;
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // instruction memory: one response per request after lat cycles, plus injected strays
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (rst) mem_pend = 1'b0;
         if (stray_req) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray_req   = 1'b0;
         end else if (mem_pend) begin
            if (mem_cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(mem_addr_q);
               mem_pend    = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
         if (imem_req) begin
            mem_pend   = 1'b1;
            mem_cnt    = lat;
            mem_addr_q = imem_addr;
         end
      end
   end

   // compare process: check this cycle's outputs, then apply the coming edge to the model
   always @(negedge clk) begin
      logic        redir;
      logic [31:0] target;
      if (m_live) begin
         if (imem_req) begin
            check("single_outstanding", {31'h0, m_outstanding}, 32'h0);
            check("fetch_addr", imem_addr, m_next_addr);
            m_outstanding = 1'b1;
            m_stale       = 1'b0;
            m_out_addr    = m_next_addr;
            m_addr_hold   = m_next_addr;
            m_next_addr   = m_next_addr + 32'd4;
         end else begin
            check("addr_hold", imem_addr, m_addr_hold);
         end
         check("instr_valid", {31'h0, instr_valid}, {31'h0, m_show});
         if (m_show) begin
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_pc);
         end
      end
      if (rst) begin
         m_live        = 1'b1;
         m_next_addr   = 32'h0;
         m_addr_hold   = 32'h0;
         m_outstanding = 1'b0;
         m_stale       = 1'b0;
         m_show        = 1'b0;
         m_last_pc     = 32'h0;
         m_pc          = 32'h0;
         m_instr       = 32'h0;
         m_out_addr    = 32'h0;
      end else if (m_live) begin
         redir  = redirect_valid || jump_valid;
         target = redirect_valid ? {redirect_target[31:2], 2'b00}
                                 : {m_last_pc[31:28], j_addr, 2'b00};
         if (m_show && dec_ready && !redir) m_show = 1'b0;
         if (redir) begin
            m_next_addr = target;
            m_show      = 1'b0;
            if (m_outstanding) m_stale = 1'b1;
         end
         if (imem_rvalid && m_outstanding) begin
            m_outstanding = 1'b0;
            if (!m_stale) begin
               m_show    = 1'b1;
               m_pc      = m_out_addr;
               m_instr   = mem_word(m_out_addr);
               m_last_pc = m_out_addr;
            end
         end
      end
   end

   task automatic wait_req(output logic [31:0] a, output logic saw_valid);
      int n = 0;
      saw_valid = 1'b0;
      do begin
         @(posedge clk);
         #2;
         n++;
         if (instr_valid) saw_valid = 1'b1;
      end while (!imem_req && n < 40);
      if (!imem_req) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: got no imem_req, expected one within 40 cycles");
      end
      a = imem_addr;
   endtask

   task automatic wait_valid(output logic [31:0] p, output logic [31:0] d);
      int n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!instr_valid && n < 40);
      if (!instr_valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no instr_valid, expected one within 40 cycles");
      end
      p = instr_pc;
      d = instr;
   endtask

   task automatic pulse(input logic r, input logic [31:0] t, input logic j, input logic [25:0] ja);
      redirect_valid  = r;
      redirect_target = t;
      jump_valid      = j;
      j_addr          = ja;
      @(posedge clk);
      #2;
      redirect_valid = 1'b0;
      jump_valid     = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_imem_req", {31'h0, imem_req}, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
   endtask

   initial begin
      logic [31:0] a, p, d;
      logic        sv;
      logic [31:0] exp_words [4];
      exp_words = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'h1234_5678};
      rst = 1'b1; dec_ready = 1'b1; jump_valid = 1'b0; j_addr = 26'h0;
      redirect_valid = 1'b0; redirect_target = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs();
      rst = 1'b0;

      // sequential fetch at latency 1; the fourth word is held by the decoder
      for (int i = 0; i < 4; i++) begin
         wait_req(a, sv);
         check("seq_addr", a, 32'(i * 4));
         if (i == 3) dec_ready = 1'b0;
         wait_valid(p, d);
         check("seq_pc", p, a);
         check("seq_word", d, exp_words[i]);
      end

      // decoder stall: word and pc stable, no request until the handshake edge
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         check("stall_instr", instr, 32'h1234_5678);
         check("stall_pc", instr_pc, 32'h0000_000C);
         check("stall_no_req", {31'h0, imem_req}, 32'h0);
      end
      dec_ready = 1'b1;
      @(posedge clk);
      #2;
      dec_ready = 1'b0;
      check("release_req", {31'h0, imem_req}, 32'h1);
      check("release_addr", imem_addr, 32'h0000_0010);
      check("release_valid", {31'h0, instr_valid}, 32'h0);
      wait_valid(p, d);
      check("pc_10", p, 32'h0000_0010);

      // jump relative to the held instr_pc region
      pulse(1'b1, 32'h4000_0008, 1'b0, 26'h0);
      wait_req(a, sv);
      check("redir_addr", a, 32'h4000_0008);
      wait_valid(p, d);
      check("held_pc", p, 32'h4000_0008);
      lat = 3;
      pulse(1'b0, 32'h0, 1'b1, 26'h000_0010);
      check("jump_squash", {31'h0, instr_valid}, 32'h0);
      wait_req(a, sv);
      check("jump_addr", a, 32'h4000_0040);

      // redirect during WAIT, stale response arrives 3 cycles after the request
      pulse(1'b1, 32'h0000_0103, 1'b0, 26'h0);
      wait_req(a, sv);
      check("drop_addr", a, 32'h0000_0100);
      check("drop_hidden", {31'h0, sv}, 32'h0);
      wait_valid(p, d);
      check("drop_word", d, 32'hC0DE_0100);

      // redirect beats jump; then a redirect coincident with rvalid
      lat = 1;
      pulse(1'b1, 32'h0000_0200, 1'b1, 26'h000_003F);
      wait_req(a, sv);
      check("prio_addr", a, 32'h0000_0200);
      @(posedge clk);
      #2;
      pulse(1'b1, 32'h0000_0300, 1'b0, 26'h0);
      wait_req(a, sv);
      check("coinc_addr", a, 32'h0000_0300);
      check("coinc_hidden", {31'h0, sv}, 32'h0);

      // wrap at the top of memory, then reset mid-WAIT and a stray response
      dec_ready = 1'b1;
      pulse(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
      wait_req(a, sv);
      check("top_addr", a, 32'hFFFF_FFFC);
      wait_valid(p, d);
      check("top_word", d, 32'h3F21_FFFC);
      lat = 3;
      wait_req(a, sv);
      check("wrap_addr", a, 32'h0000_0000);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_reset_outputs();
      stray_req = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      check("stray_ignored", {31'h0, instr_valid}, 32'h0);
      check("post_rst_req", {31'h0, imem_req}, 32'h1);
      wait_valid(p, d);
      check("post_rst_pc", p, 32'h0000_0000);
      check("post_rst_word", d, 32'hC0DE_0000);
      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
